fp_operand_loader: RTL and testbench

// - Sequential front end for the IEEE-754 single-precision multiplier unit.
// - Assembles operands A and B from narrow chunks, e.g. board switches strobed by a debounced key.
// - Presents both operands atomically on dataA/dataB with a valid/ready handshake.
// - Optionally registers special-case operand flags alongside the operands.

---
 rtl/fp_operand_loader.sv | 135 +++++++++++++
 tb/tb_fp_operand_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_operand_loader.sv
// fp_operand_loader: assembles two 32-bit FP operands from CHUNK_W-bit strobed chunks and
// presents them atomically with valid/ready. Define SPECIAL_CHECK_EN to register special-case flags.
module fp_operand_loader #(
  parameter  int CHUNK_W = 8,
  localparam int NCHUNK  = 32 / CHUNK_W,
  localparam int CNT_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               load,
  input  logic [CHUNK_W-1:0] data_in,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [31:0]        dataA,
  output logic [31:0]        dataB,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   chunk_cnt,
  output logic               overrun,
  output logic [3:0]         special_flags
);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    READY  = 2'b10
  } state_t;

  state_t      st;
  logic [31:0] sr_a, sr_b;
  logic [31:0] sr_a_nxt, sr_b_nxt;
  logic        last_chunk;
  logic        complete;

  // Shifting by a full 32 bits yields zero, so CHUNK_W=32 degenerates to a plain capture.
  assign sr_a_nxt   = (sr_a << CHUNK_W) | 32'(data_in);
  assign sr_b_nxt   = (sr_b << CHUNK_W) | 32'(data_in);
  assign last_chunk = (chunk_cnt == CNT_W'(NCHUNK - 1));
  assign complete   = !clear && (st == LOAD_B) && load && last_chunk;
  assign state      = st;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= LOAD_A;
      chunk_cnt <= '0;
      sr_a      <= '0;
      sr_b      <= '0;
      dataA     <= '0;
      dataB     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (clear) begin
      st        <= LOAD_A;
      chunk_cnt <= '0;
      sr_a      <= '0;
      sr_b      <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      case (st)
        LOAD_A: begin
          if (load) begin
            sr_a <= sr_a_nxt;
            if (last_chunk) begin
              chunk_cnt <= '0;
              st        <= LOAD_B;
            end else begin
              chunk_cnt <= chunk_cnt + CNT_W'(1);
            end
          end
        end
        LOAD_B: begin
          if (load) begin
            sr_b <= sr_b_nxt;
            if (last_chunk) begin
              chunk_cnt <= '0;
              dataA     <= sr_a;
              dataB     <= sr_b_nxt;
              out_valid <= 1'b1;
              st        <= READY;
            end else begin
              chunk_cnt <= chunk_cnt + CNT_W'(1);
            end
          end
        end
        READY: begin
          if (load) overrun <= 1'b1;
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            chunk_cnt <= '0;
            st        <= LOAD_A;
          end
        end
        default: begin
          st        <= LOAD_A;
          chunk_cnt <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPECIAL_CHECK_EN
  logic [3:0] flags_reg, flags_nxt;
  logic [2:0] cls_a, cls_b;

  // Returns {nan, inf, zero}; the sign bit plays no part.
  function automatic logic [2:0] classify(input logic [30:0] v);
    logic exp_ones, exp_zero, mant_zero;
    exp_ones  = (v[30:23] == 8'hFF);
    exp_zero  = (v[30:23] == 8'h00);
    mant_zero = (v[22:0] == 23'd0);
    return {exp_ones && !mant_zero, exp_ones && mant_zero, exp_zero && mant_zero};
  endfunction

  always_comb begin
    cls_a     = classify(sr_a[30:0]);
    cls_b     = classify(sr_b_nxt[30:0]);
    flags_nxt = {cls_a[2] | cls_b[2],
                 cls_a[1] | cls_b[1],
                 cls_a[0] | cls_b[0],
                 (cls_a[1] & cls_b[0]) | (cls_a[0] & cls_b[1])};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         flags_reg <= '0;
    else if (complete) flags_reg <= flags_nxt;
  end

  assign special_flags = flags_reg;
`else
  assign special_flags = 4'b0;
`endif

endmodule

// File: tb/tb_fp_operand_loader.sv
// Self-checking bench for fp_operand_loader: table vectors, directed corner sequences,
// random traffic against a chunk-queue reference model, plus a CHUNK_W=32 instance.
module tb_fp_operand_loader;
  localparam int NCH = 4;
`ifdef SPECIAL_CHECK_EN
  localparam bit SPECIAL = 1'b1;
`else
  localparam bit SPECIAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1, clear = 1'b0, load = 1'b0, out_ready = 1'b0;
  logic [7:0]  data_in = '0;
  logic        out_valid, overrun;
  logic [31:0] dataA, dataB;
  logic [1:0]  state;
  logic [1:0]  chunk_cnt;
  logic [3:0]  special_flags;

  logic        load32 = 1'b0, rdy32 = 1'b0;
  logic [31:0] din32 = '0;
  logic        v32, ovr32;
  logic [31:0] a32, b32;
  logic [1:0]  st32;
  logic [0:0]  cnt32;
  logic [3:0]  fl32;

  always #5 clk = ~clk;

  fp_operand_loader #(.CHUNK_W(8)) dut (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .data_in(data_in),
    .out_ready(out_ready), .out_valid(out_valid), .dataA(dataA), .dataB(dataB),
    .state(state), .chunk_cnt(chunk_cnt), .overrun(overrun), .special_flags(special_flags)
  );

  fp_operand_loader #(.CHUNK_W(32)) dut32 (
    .clk(clk), .reset(reset), .clear(1'b0), .load(load32), .data_in(din32),
    .out_ready(rdy32), .out_valid(v32), .dataA(a32), .dataB(b32),
    .state(st32), .chunk_cnt(cnt32), .overrun(ovr32), .special_flags(fl32)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: chunks accepted so far for the pending pair, plus the presented pair.
  logic [7:0]  mq[$];
  bit          m_valid, m_ovr;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_fl;

  function automatic logic [3:0] ref_flags(input logic [31:0] a, input logic [31:0] b);
    bit an, ai, az, bn, bi, bz;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    az = (a[30:0] == 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    bz = (b[30:0] == 0);
    return SPECIAL ? {an | bn, ai | bi, az | bz, (ai && bz) || (az && bi)} : 4'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_valid = 0; m_ovr = 0; m_a = 0; m_b = 0; m_fl = 0;
  endtask

  task automatic model_step(input bit clr, input bit ld, input logic [7:0] d, input bit rdy);
    if (clr) begin
      mq.delete();
      m_valid = 0;
      m_ovr   = 0;
    end else if (m_valid) begin
      if (ld) m_ovr = 1;
      if (rdy) m_valid = 0;
    end else if (ld) begin
      mq.push_back(d);
      if (mq.size() == 2 * NCH) begin
        m_a = 0; m_b = 0;
        for (int i = 0; i < NCH; i++) begin
          m_a = m_a * 256 + 32'(mq[i]);
          m_b = m_b * 256 + 32'(mq[NCH + i]);
        end
        m_fl    = ref_flags(m_a, m_b);
        m_valid = 1;
        mq.delete();
      end
    end
  endtask

  task automatic check_all(input string tag);
    int exp_state;
    exp_state = m_valid ? 2 : ((mq.size() >= NCH) ? 1 : 0);
    chk({tag, "_valid"}, out_valid, m_valid);
    chk({tag, "_dataA"}, dataA, m_a);
    chk({tag, "_dataB"}, dataB, m_b);
    chk({tag, "_state"}, state, exp_state);
    chk({tag, "_cnt"}, chunk_cnt, mq.size() % NCH);
    chk({tag, "_ovr"}, overrun, m_ovr);
    chk({tag, "_flags"}, special_flags, m_fl);
  endtask

  task automatic cycle(input bit clr, input bit ld, input logic [7:0] d, input bit rdy);
    clear = clr; load = ld; data_in = d; out_ready = rdy;
    @(posedge clk);
    model_step(clr, ld, d, rdy);
    #1;
    clear = 0; load = 0; out_ready = 0;
  endtask

  // Loads the first n chunks of the pair (a,b), MSB chunk first, checking after each.
  task automatic load_chunks(input logic [31:0] a, input logic [31:0] b, input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = (i < NCH) ? a : b;
      cycle(0, 1, 8'(w >> (8 * (NCH - 1 - (i % NCH)))), 0);
      check_all("load");
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  fl;
  } vec_t;

  vec_t tab[6];

  initial begin
    tab[0] = '{32'h41480000, 32'hC0A66666, 4'b0000};
    tab[1] = '{32'h7F800000, 32'h00000000, 4'b0111};
    tab[2] = '{32'h7FC00000, 32'h3F800000, 4'b1000};
    tab[3] = '{32'h3F800000, 32'h80000000, 4'b0010};
    tab[4] = '{32'hFF800000, 32'h7F800001, 4'b1100};
    tab[5] = '{32'h00000000, 32'hFF800000, 4'b0111};

    model_reset();
    #12;
    check_all("rst");
    chk("rst_state", state, 0);
    chk("rst_valid", out_valid, 0);
    @(posedge clk); #1;
    reset = 0;

    foreach (tab[k]) begin
      load_chunks(tab[k].a, tab[k].b, 2 * NCH);
      chk("tab_valid", out_valid, 1);
      chk("tab_dataA", dataA, tab[k].a);
      chk("tab_dataB", dataB, tab[k].b);
      chk("tab_flags", special_flags, SPECIAL ? tab[k].fl : 4'b0);
      cycle(0, 0, 0, 1);
      check_all("tab_ack");
      chk("tab_ack_state", state, 0);
    end

    // Loads while READY are dropped and flagged; acceptance keeps the sticky flag.
    load_chunks(32'h41480000, 32'hC0A66666, 2 * NCH);
    cycle(0, 1, 8'hAA, 0);
    cycle(0, 1, 8'h55, 0);
    check_all("ovr");
    chk("ovr_dataA", dataA, 32'h41480000);
    chk("ovr_dataB", dataB, 32'hC0A66666);
    chk("ovr_flag", overrun, 1);
    cycle(0, 0, 0, 1);
    check_all("ovr_ack");
    chk("ovr_ack_state", state, 0);
    chk("ovr_ack_valid", out_valid, 0);
    chk("ovr_ack_flag", overrun, 1);

    // Clear part-way through B: previous pair is retained.
    load_chunks(32'h3F800000, 32'h12345678, NCH + 2);
    chk("pre_clr_state", state, 1);
    chk("pre_clr_cnt", chunk_cnt, 2);
    cycle(1, 1, 8'hEE, 1);
    check_all("clr");
    chk("clr_state", state, 0);
    chk("clr_cnt", chunk_cnt, 0);
    chk("clr_ovr", overrun, 0);
    chk("clr_dataA", dataA, 32'h41480000);
    chk("clr_dataB", dataB, 32'hC0A66666);
    load_chunks(32'h3F800000, 32'h40000000, 2 * NCH);
    chk("post_clr_dataA", dataA, 32'h3F800000);
    chk("post_clr_dataB", dataB, 32'h40000000);
    cycle(0, 0, 0, 1);

    // Asynchronous reset after 5 chunks takes effect before the next edge.
    load_chunks(32'h11223344, 32'h55667788, 5);
    chk("pre_rst_state", state, 1);
    chk("pre_rst_cnt", chunk_cnt, 1);
    reset = 1;
    model_reset();
    #2;
    check_all("arst");
    chk("arst_state", state, 0);
    chk("arst_dataA", dataA, 0);
    @(posedge clk); #1;
    reset = 0;
    load_chunks(32'h41480000, 32'hC0A66666, 2 * NCH);
    chk("post_rst_dataA", dataA, 32'h41480000);
    chk("post_rst_dataB", dataB, 32'hC0A66666);
    cycle(0, 0, 0, 1);
    check_all("post_rst_ack");

    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 29) == 0, $urandom_range(0, 9) < 7,
            8'($urandom), $urandom_range(0, 1) == 1);
      check_all("rand");
    end

    // One load per operand at CHUNK_W=32.
    load32 = 1; din32 = 32'h41480000;
    @(posedge clk); #1;
    chk("w32_a_valid", v32, 0);
    chk("w32_a_state", st32, 1);
    chk("w32_a_cnt", cnt32, 0);
    din32 = 32'hC0A66666;
    @(posedge clk); #1;
    load32 = 0;
    chk("w32_valid", v32, 1);
    chk("w32_dataA", a32, 32'h41480000);
    chk("w32_dataB", b32, 32'hC0A66666);
    chk("w32_state", st32, 2);
    chk("w32_cnt", cnt32, 0);
    chk("w32_flags", fl32, ref_flags(32'h41480000, 32'hC0A66666));
    rdy32 = 1;
    @(posedge clk); #1;
    rdy32 = 0;
    chk("w32_ack_valid", v32, 0);
    chk("w32_ack_state", st32, 0);
    chk("w32_ovr", ovr32, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
